// File: rtl/replace_ctrl_pkg.sv
// Shared types and tree-PLRU helpers for the replacement controller.
//
// Contents:
//   state_t            miss-sequencer states (IDLE, SELECT, FILL, UPDATE)
//   plru_victim()      walk a heap-ordered PLRU tree and return the victim way index
//   plru_update()      point every node on a way's path away from that way
//   first_zero_onehot() one-hot of the lowest cleared bit
//   lowest_one_idx()   index of the lowest set bit
//
// The helpers operate on 16-bit containers so they serve every WAY_NUM from
// 2 to 16. Callers zero-extend their operands and pass the tree depth
// ($clog2(WAY_NUM)) explicitly.
package replace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    FILL   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Bit value 0 steers to the lower half and 1 to the upper half. The
  // bit read at each level becomes the next bit of the way index, MSB first.
  function automatic logic [3:0] plru_victim(input logic [15:0] bits, input int lvls);
    logic [3:0] idx;
    logic [4:0] node;
    idx  = '0;
    node = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < lvls) begin
        idx  = {idx[2:0], bits[node[3:0]]};
        node = {node[3:0], 1'b0} + 5'd1 + {4'd0, bits[node[3:0]]};
      end
    end
    return idx;
  endfunction

  // Each node on the path gets the inverse of the branch that was taken.
  function automatic logic [15:0] plru_update(input logic [15:0] bits, input logic [3:0] way,
                                              input int lvls);
    logic [15:0] nb;
    logic [4:0]  node;
    logic        dir;
    nb   = bits;
    node = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < lvls) begin
        dir           = way[2'(lvls - 1 - l)];
        nb[node[3:0]] = ~dir;
        node          = {node[3:0], 1'b0} + 5'd1 + {4'd0, dir};
      end
    end
    return nb;
  endfunction

  function automatic logic [15:0] first_zero_onehot(input logic [15:0] valid);
    logic [15:0] inv;
    inv = ~valid;
    return inv & (~inv + 16'd1);
  endfunction

  function automatic logic [3:0] lowest_one_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/replace_ctrl_if.sv
// Bus bundle between the cache tag/hit logic, the refill engine and
// replace_ctrl.
//
// Signals: hit_valid/hit_set/hit_way (hit update), miss_req/miss_set/
// miss_valid/miss_ack (miss handshake), fill_req/fill_set/fill_way/fill_done
// (fill handshake), busy, and dbg_state (the FSM state, for observation).
//
// Handshakes: miss_req is a level that the requester holds until the
// one-cycle miss_ack pulse; it is accepted only while the controller is
// idle. fill_req stays high with fill_set/fill_way stable until fill_done
// is sampled high; fill_done has no meaning outside that window.
interface replace_ctrl_if #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 128
);
  import replace_pkg::*;

  localparam int SET_W = $clog2(SET_NUM);

  logic               hit_valid;
  logic [SET_W-1:0]   hit_set;
  logic [WAY_NUM-1:0] hit_way;
  logic               miss_req;
  logic [SET_W-1:0]   miss_set;
  logic [WAY_NUM-1:0] miss_valid;
  logic               miss_ack;
  logic               fill_req;
  logic [SET_W-1:0]   fill_set;
  logic [WAY_NUM-1:0] fill_way;
  logic               fill_done;
  logic               busy;
  state_t             dbg_state;

  modport master (
    output hit_valid, hit_set, hit_way, miss_req, miss_set, miss_valid, fill_done,
    input  miss_ack, fill_req, fill_set, fill_way, busy, dbg_state
  );

  modport slave (
    input  hit_valid, hit_set, hit_way, miss_req, miss_set, miss_valid, fill_done,
    output miss_ack, fill_req, fill_set, fill_way, busy, dbg_state
  );
endinterface

// File: rtl/replace_ctrl_plru_tree.sv
// plru_tree: combinational tree-PLRU calculator for one set.
//
// Ports:
//   bits_i       current PLRU bits of the set (heap order, node 0 = root)
//   way_i        way index being accessed
//   victim_o     PLRU victim index derived from bits_i
//   next_bits_o  bits_i after an access to way_i
module plru_tree
  import replace_pkg::*;
#(
  parameter int WAY_NUM = 4
) (
  input  logic [WAY_NUM-2:0]         bits_i,
  input  logic [$clog2(WAY_NUM)-1:0] way_i,
  output logic [$clog2(WAY_NUM)-1:0] victim_o,
  output logic [WAY_NUM-2:0]         next_bits_o
);
  localparam int IDX_W = $clog2(WAY_NUM);

  logic [15:0] bits_ext;
  logic [15:0] next_ext;
  logic [3:0]  way_ext;
  logic [3:0]  victim_ext;

  assign bits_ext    = 16'(bits_i);
  assign way_ext     = 4'(way_i);
  assign victim_ext  = plru_victim(bits_ext, IDX_W);
  assign next_ext    = plru_update(bits_ext, way_ext, IDX_W);
  assign victim_o    = victim_ext[IDX_W-1:0];
  assign next_bits_o = next_ext[WAY_NUM-2:0];

  // Upper container bits beyond this tree's size are always zero.
  logic unused_ext;
  assign unused_ext = ^{victim_ext, next_ext};
endmodule

// File: rtl/replace_ctrl.sv
// replace_ctrl: per-set replacement controller and miss sequencer.
//
// Holds tree-PLRU state for every set, updates it on hits, and on a miss
// picks a victim (lowest invalid way first, else PLRU), runs the fill
// handshake with the refill engine, then commits the replacement update.
//
// Ports: cache_clk, rst (synchronous, active-high), bus (replace_ctrl_if
// slave modport: hit, miss and fill signals plus busy and dbg_state).
//
// Build option: define REPLACE_RANDOM_EN to drop the PLRU array; the
// full-valid victim then comes from a counter that advances on each UPDATE
// and hit updates are ignored.
module replace_ctrl
  import replace_pkg::*;
#(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 128
) (
  input logic           cache_clk,
  input logic           rst,
  replace_ctrl_if.slave bus
);
  localparam int SET_W = $clog2(SET_NUM);
  localparam int IDX_W = $clog2(WAY_NUM);

  state_t             state_q;
  logic [SET_W-1:0]   set_q;
  logic [WAY_NUM-1:0] valid_q;
  logic [SET_W-1:0]   fill_set_q;
  logic [WAY_NUM-1:0] fill_way_q;
  logic [IDX_W-1:0]   victim_q;

  // Invalid-way priority: lowest cleared valid bit. Bits above WAY_NUM are
  // forced to 1 so they never look invalid.
  logic [15:0]      valid_ext;
  logic [15:0]      inv_oh_ext;
  logic [3:0]       inv_idx_ext;
  logic             any_invalid;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] repl_idx;
  logic [IDX_W-1:0] chosen_idx;

  always_comb begin
    valid_ext                = '1;
    valid_ext[WAY_NUM-1:0]   = valid_q;
  end

  assign inv_oh_ext  = first_zero_onehot(valid_ext);
  assign inv_idx_ext = lowest_one_idx(inv_oh_ext);
  assign any_invalid = |inv_oh_ext;
  assign inv_idx     = inv_idx_ext[IDX_W-1:0];
  assign chosen_idx  = any_invalid ? inv_idx : repl_idx;

  logic unused_inv;
  assign unused_inv = ^inv_idx_ext;

`ifdef REPLACE_RANDOM_EN
  logic [IDX_W-1:0] rnd_q;

  assign repl_idx = rnd_q;

  always_ff @(posedge cache_clk) begin
    if (rst) begin
      rnd_q <= '0;
    end else if (state_q == UPDATE) begin
      rnd_q <= rnd_q + IDX_W'(1);
    end
  end

  logic unused_hit;
  assign unused_hit = ^{bus.hit_valid, bus.hit_set, bus.hit_way};
`else
  logic [WAY_NUM-2:0] plru_q [SET_NUM];

  logic               hit_en;
  logic [15:0]        hit_way_ext;
  logic [3:0]         hit_idx_ext;
  logic [IDX_W-1:0]   hit_idx;
  logic [WAY_NUM-2:0] hit_cur;
  logic [WAY_NUM-2:0] hit_next;
  logic [WAY_NUM-2:0] sel_bits;
  logic [WAY_NUM-2:0] fill_next;
  logic [IDX_W-1:0]   unused_hit_victim;

  // A zero hit_way carries no access; multi-hot resolves to its lowest way.
  assign hit_en      = bus.hit_valid && (|bus.hit_way);
  assign hit_way_ext = 16'(bus.hit_way);
  assign hit_idx_ext = lowest_one_idx(hit_way_ext);
  assign hit_idx     = hit_idx_ext[IDX_W-1:0];
  assign hit_cur     = plru_q[bus.hit_set];

  plru_tree #(.WAY_NUM(WAY_NUM)) u_hit_tree (
    .bits_i      (hit_cur),
    .way_i       (hit_idx),
    .victim_o    (unused_hit_victim),
    .next_bits_o (hit_next)
  );

  // A hit landing on the captured set during SELECT is forwarded so the
  // victim is chosen from the post-hit bits. In UPDATE this port computes
  // the fill update from the stored bits of the filled set.
  assign sel_bits = (state_q == SELECT && hit_en && bus.hit_set == set_q) ? hit_next
                                                                           : plru_q[set_q];

  plru_tree #(.WAY_NUM(WAY_NUM)) u_fill_tree (
    .bits_i      (sel_bits),
    .way_i       (victim_q),
    .victim_o    (repl_idx),
    .next_bits_o (fill_next)
  );

  // The fill write comes last so it overrides a same-set hit in UPDATE.
  always_ff @(posedge cache_clk) begin
    if (rst) begin
      for (int s = 0; s < SET_NUM; s++) plru_q[s] <= '0;
    end else begin
      if (hit_en) plru_q[bus.hit_set] <= hit_next;
      if (state_q == UPDATE) plru_q[fill_set_q] <= fill_next;
    end
  end

  logic unused_hidx;
  assign unused_hidx = ^hit_idx_ext;
`endif

  always_ff @(posedge cache_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      set_q      <= '0;
      valid_q    <= '0;
      fill_set_q <= '0;
      fill_way_q <= '0;
      victim_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.miss_req) begin
            set_q   <= bus.miss_set;
            valid_q <= bus.miss_valid;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          fill_set_q <= set_q;
          fill_way_q <= WAY_NUM'(1) << chosen_idx;
          victim_q   <= chosen_idx;
          state_q    <= FILL;
        end
        FILL: begin
          if (bus.fill_done) state_q <= UPDATE;
        end
        UPDATE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.miss_ack  = (state_q == UPDATE);
  assign bus.fill_req  = (state_q == FILL);
  assign bus.busy      = (state_q != IDLE);
  assign bus.fill_set  = fill_set_q;
  assign bus.fill_way  = fill_way_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_replace_ctrl.sv
module tb_replace_ctrl;
  localparam int WAYS = 4;
  localparam int SETS = 128;

  // ---------------- clock / reset ----------------
  logic cache_clk = 1'b0;
  logic rst;
  always #5 cache_clk = ~cache_clk;

  replace_ctrl_if #(.WAY_NUM(WAYS), .SET_NUM(SETS)) bus ();

  replace_ctrl #(.WAY_NUM(WAYS), .SET_NUM(SETS)) dut (
    .cache_clk (cache_clk),
    .rst       (rst),
    .bus       (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Per set: m_plru[s][0]=b0 (root), [1]=b1 (ways 0/1), [2]=b2 (ways 2/3).
  logic [2:0] m_plru [SETS];
  bit         m_active, m_sel, m_done;
  int         m_set, m_vic;
  logic [3:0] m_valid;
  logic [6:0] m_fill_set;
  logic [3:0] m_fill_way;

  function automatic int tbl_victim(input logic [2:0] b);
    if (!b[0]) return b[1] ? 1 : 0;
    return b[2] ? 3 : 2;
  endfunction

  function automatic logic [2:0] tbl_update(input logic [2:0] b, input int w);
    logic [2:0] r;
    r = b;
    case (w)
      0: begin r[0] = 1'b1; r[1] = 1'b1; end
      1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  always @(posedge cache_clk) begin
    logic [2:0] fill_new;
    int hw, vz;
    cyc++;
    if (rst) begin
      for (int s = 0; s < SETS; s++) m_plru[s] = 3'b000;
      m_active = 0; m_sel = 0; m_done = 0; m_vic = 0; m_set = 0; m_valid = '0;
      m_fill_set = '0; m_fill_way = '0;
    end else begin
      fill_new = tbl_update(m_plru[m_fill_set], m_vic);
      hw = 0;
      for (int i = 3; i >= 0; i--) if (bus.hit_way[i]) hw = i;
      if (bus.hit_valid && bus.hit_way != 4'b0000 &&
          !(m_active && m_done && int'(bus.hit_set) == int'(m_fill_set)))
        m_plru[bus.hit_set] = tbl_update(m_plru[bus.hit_set], hw);
      if (!m_active) begin
        if (bus.miss_req) begin
          m_active = 1; m_sel = 1; m_done = 0;
          m_set = int'(bus.miss_set); m_valid = bus.miss_valid;
        end
      end else if (m_sel) begin
        vz = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) vz = i;
        m_vic = (vz >= 0) ? vz : tbl_victim(m_plru[m_set]);
        m_fill_set = 7'(m_set);
        m_fill_way = 4'(1 << m_vic);
        m_sel = 0;
      end else if (m_done) begin
        m_plru[m_fill_set] = fill_new;
        m_active = 0; m_done = 0;
      end else if (bus.fill_done) begin
        m_done = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge cache_clk) begin
    if (chk_en) begin
      chk("busy",     32'(bus.busy),     32'(m_active));
      chk("fill_req", 32'(bus.fill_req), 32'(m_active && !m_sel && !m_done));
      chk("miss_ack", 32'(bus.miss_ack), 32'(m_active && m_done));
      chk("fill_set", 32'(bus.fill_set), 32'(m_fill_set));
      chk("fill_way", 32'(bus.fill_way), 32'(m_fill_way));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge cache_clk);
    #1;
  endtask

  task automatic drive_hit(input int hset, input logic [3:0] hway);
    bus.hit_valid = 1'b1;
    bus.hit_set   = 7'(hset);
    bus.hit_way   = hway;
  endtask

  task automatic clear_hit();
    bus.hit_valid = 1'b0;
    bus.hit_set   = '0;
    bus.hit_way   = '0;
  endtask

  task automatic hit_cycle(input int hset, input logic [3:0] hway);
    drive_hit(hset, hway);
    tick();
    clear_hit();
  endtask

  // hph: 0 = no hit, 1 = hit during SELECT, 2 = hit during UPDATE.
  task automatic do_miss(input int set, input logic [3:0] valid, input int fdelay,
                         input int hph, input int hset, input logic [3:0] hway,
                         output logic [3:0] way, output int lat);
    int c0, n;
    bus.miss_req   = 1'b1;
    bus.miss_set   = 7'(set);
    bus.miss_valid = valid;
    c0 = cyc;
    tick();
    if (hph == 1) drive_hit(hset, hway);
    tick();
    clear_hit();
    n = 0;
    while (bus.fill_req !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("timeout_fill_req", 32'(bus.fill_req), 32'd1);
    way = bus.fill_way;
    repeat (fdelay) tick();
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    n = 0;
    while (bus.miss_ack !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("timeout_miss_ack", 32'(bus.miss_ack), 32'd1);
    lat = cyc - c0;
    bus.miss_req = 1'b0;
    if (hph == 2) drive_hit(hset, hway);
    tick();
    clear_hit();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] w, vr, hw;
    int lat, ack_cnt, k, fd, hph, st, hs;

    rst = 1'b1;
    bus.miss_req = 1'b0; bus.miss_set = '0; bus.miss_valid = '0; bus.fill_done = 1'b0;
    clear_hit();
    @(posedge cache_clk);
    @(posedge cache_clk);
    #1;
    chk_en = 1;
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_fill_req", 32'(bus.fill_req), 32'd0);
    chk("rst_fill_way", 32'(bus.fill_way), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: fresh PLRU picks way0, then way2; minimum latency.
    do_miss(5, 4'hf, 0, 0, 0, 4'b0000, w, lat);
    chk("t1_way_first", 32'(w), 32'h1);
    chk("t1_latency", 32'(lat), 32'd3);
    do_miss(5, 4'hf, 0, 0, 0, 4'b0000, w, lat);
    chk("t1_way_second", 32'(w), 32'h4);

    // Test 2: PLRU points at way3 but the invalid way2 wins.
    hit_cycle(7, 4'b0001);
    hit_cycle(7, 4'b0100);
    hit_cycle(7, 4'b0001);
    chk("t2_model_victim", 32'(tbl_victim(m_plru[7])), 32'd3);
    do_miss(7, 4'b1011, 0, 0, 0, 4'b0000, w, lat);
    chk("t2_way", 32'(w), 32'h4);
    chk("t2_model_b0", 32'(m_plru[7][0]), 32'd0);
    chk("t2_model_b2", 32'(m_plru[7][2]), 32'd1);
    do_miss(7, 4'hf, 0, 0, 0, 4'b0000, w, lat);
    chk("t2_way_after", 32'(w), 32'h2);

    // Test 3: hits to ways 0..3 leave way0 as PLRU victim.
    for (int i = 0; i < 4; i++) hit_cycle(3, 4'(1 << i));
    do_miss(3, 4'hf, 0, 0, 0, 4'b0000, w, lat);
    chk("t3_way", 32'(w), 32'h1);

    // Test 4: long fill with a toggling request on another set.
    bus.miss_req = 1'b1; bus.miss_set = 7'd9; bus.miss_valid = 4'hf;
    tick();
    tick();
    chk("t4_fill_req", 32'(bus.fill_req), 32'd1);
    chk("t4_way", 32'(bus.fill_way), 32'h1);
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.miss_req = i[0];
      bus.miss_set = 7'd10;
      tick();
      if (bus.miss_ack === 1'b1) ack_cnt++;
    end
    chk("t4_no_ack", 32'(ack_cnt), 32'd0);
    chk("t4_fill_set_stable", 32'(bus.fill_set), 32'd9);
    chk("t4_busy", 32'(bus.busy), 32'd1);
    bus.miss_req = 1'b1;
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    chk("t4_ack", 32'(bus.miss_ack), 32'd1);
    tick();
    chk("t4_idle_between", 32'(bus.busy), 32'd0);
    tick();
    chk("t4_restart", 32'(bus.busy), 32'd1);
    tick();
    chk("t4_new_fill_set", 32'(bus.fill_set), 32'd10);
    chk("t4_new_fill_way", 32'(bus.fill_way), 32'h1);
    bus.fill_done = 1'b1;
    tick();
    bus.fill_done = 1'b0;
    chk("t4_new_ack", 32'(bus.miss_ack), 32'd1);
    bus.miss_req = 1'b0;
    tick();

    // Hit in SELECT on the captured set steers the victim.
    do_miss(11, 4'hf, 0, 1, 11, 4'b0001, w, lat);
    chk("sel_hit_way", 32'(w), 32'h4);

    // Test 6: reset during FILL aborts silently and clears PLRU.
    bus.miss_req = 1'b1; bus.miss_set = 7'd2; bus.miss_valid = 4'hf;
    tick();
    tick();
    tick();
    rst = 1'b1;
    bus.miss_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6_fill_req", 32'(bus.fill_req), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ack", 32'(bus.miss_ack), 32'd0);
    do_miss(7, 4'hf, 0, 0, 0, 4'b0000, w, lat);
    chk("t6_way", 32'(w), 32'h1);

    // Test 5: same-set hit in UPDATE is dropped; other-set hit applies.
    do_miss(5, 4'b1110, 0, 2, 5, 4'b1000, w, lat);
    chk("t5_way", 32'(w), 32'h1);
    chk("t5_model_bits", 32'(m_plru[5]), 32'h3);
    do_miss(5, 4'hf, 0, 0, 0, 4'b0000, w, lat);
    chk("t5_way_after", 32'(w), 32'h4);
    do_miss(5, 4'b1110, 0, 2, 6, 4'b0001, w, lat);
    chk("t5b_way", 32'(w), 32'h1);
    chk("t5b_model_set6", 32'(m_plru[6]), 32'h3);
    do_miss(6, 4'hf, 0, 0, 0, 4'b0000, w, lat);
    chk("t5b_way_set6", 32'(w), 32'h4);

    // Randomized traffic against the model.
    for (int it = 0; it < 150; it++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        bus.hit_valid = 1'($urandom_range(0, 1));
        bus.hit_set   = 7'($urandom_range(0, 7));
        bus.hit_way   = 4'($urandom_range(0, 15));
        tick();
      end
      clear_hit();
      vr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
      fd  = $urandom_range(0, 3);
      hph = $urandom_range(0, 2);
      st  = $urandom_range(0, 7);
      hs  = $urandom_range(0, 7);
      hw  = 4'($urandom_range(0, 15));
      do_miss(st, vr, fd, hph, hs, hw, w, lat);
      chk("rnd_latency", 32'(lat), 32'(3 + fd));
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
